note_judge_ctrl: RTL and testbench
==================================

# note_judge_ctrl

Sequencer and judge for one player lane of the rhythm game. Steps the row index through the note pattern on each beat tick, decodes the A/S/D keycode bytes into a one-hot lane mask and detects new presses. Judges each row exactly once as hit or miss, and maintains score, combo and end-of-song status. Sits between the USB keycode register, the note-pattern array (indexed externally by `row_counter`) and the score/HUD display logic.

## Interface
- `NUM_ROWS`, 100: rows in the song; last judged row is `NUM_ROWS-1`.
- `HIT_POINTS`, 10: points added per hit.
- `COMBO_BONUS`, 5: extra points per hit when pre-hit `combo` >= `COMBO_THRESH`.
- `COMBO_THRESH`, 8: combo level that enables the bonus.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins or restarts a song.
- `beat_tick`  in  1  one-cycle pulse; closes the current row.
- `keycode`  in  16  two USB key bytes, `[15:8]` and `[7:0]`.
- `row_note`  in  3  pattern at `row_counter`: `100` = left, `010` = middle, `001` = right, `000` = rest.
- `row_counter`  out  7  current row index.
- `hit`  out  1  one-cycle pulse on a correct judgment.
- `miss`  out  1  one-cycle pulse on a wrong or missing judgment.
- `score`  out  16  accumulated score, saturating.
- `combo`  out  8  consecutive hits, saturating at 255.
- `max_combo`  out  8  highest combo this song.
- `playing`  out  1  high in PLAY.
- `game_over`  out  1  high in DONE.

## Operation
- **Decode.** Each keycode byte maps independently: `0x04` -> `100`, `0x16` -> `010`, `0x07` -> `001`, anything else -> `000`. `key_mask` is the OR of the two byte results.
- **Edge detect.** `prev_mask` is registered `key_mask`, updated every cycle in every state. `new_press = key_mask & ~prev_mask`. A held key never re-triggers, and a key held through `start` is not a press.
- **FSM.** States are IDLE (reset state), PLAY and DONE.
  - IDLE: on `start`, clear `row_counter`, `score`, `combo`, `max_combo` and `judged`, then go to PLAY.
  - PLAY: judge rows as below. `start` is ignored.
  - On `beat_tick` with `row_counter == NUM_ROWS-1`: close the row, then go to DONE with `row_counter` held at `NUM_ROWS-1`.
  - DONE: outputs hold. `start` clears everything exactly as from IDLE and goes to PLAY.
- **Judgment (PLAY only).** `judged` is a per-row flag.
  - If `!judged && new_press != 0 && row_note != 0`: hit when `new_press == row_note` exactly, otherwise miss. Set `judged`.
  - A chord such as `110` against `100` is a miss.
  - Presses on a rest row (`row_note == 0`) are ignored and never judged.
  - Presses after `judged` is set are ignored until the next row.
- **Row close.** On `beat_tick`:
  - If `!judged && row_note != 0`, issue a miss.
  - Increment `row_counter` (unless at the last row) and clear `judged`.
- **Simultaneous press and beat_tick.** The press is judged against the old row first. If it produces a hit or miss, no close-miss is added. Exactly one judgment per non-rest row.
- **Hit.** `score += HIT_POINTS`, plus `COMBO_BONUS` if the pre-hit `combo >= COMBO_THRESH`; saturate at `16'hFFFF`. `combo` increments (saturating). `max_combo` updates to `max(max_combo, new combo)`.
- **Miss.** `combo` <= 0. `score` unchanged.

## Timing
- All outputs are registered.
- Reset values: `row_counter` = 0, `hit` = 0, `miss` = 0, `score` = 0, `combo` = 0, `max_combo` = 0, `playing` = 0, `game_over` = 0. Internally, state = IDLE, `prev_mask` = 0, `judged` = 0.
- `key_mask` to `new_press`: a press seen on `keycode` in cycle N is judged at the edge ending cycle N. `hit`/`miss`, `score` and `combo` are visible in cycle N+1.
- `beat_tick` in cycle N: `row_counter` is incremented in N+1. A close-miss pulses in N+1.
- `row_note` is combinational from the external array. It must be valid in the same cycle as the `row_counter` it corresponds to; new-row notes are valid from N+1.
- `hit` and `miss` are never high together, and each is high for exactly one cycle per judgment.
- `Reset` mid-song has priority over all inputs: next cycle is IDLE with reset values.
- `start` and `beat_tick` together in IDLE/DONE: start wins and the tick is ignored.

## Test plan
- **Basic hit.** Reset, `start`, `row_note=100`, keycode `0x0004` for 3 cycles, then `beat_tick` -> one `hit` pulse, `score`=10, `combo`=1, `row_counter`=1, no miss.
- **Wrong key, then correct key.** `row_note=010`, press `0x0007`, then `0x0016` in the same row -> one `miss`, no hit, `combo`=0, `score` unchanged.
- **No press and rest rows.** Non-rest row with no press, then `beat_tick` -> `miss` pulse the cycle after the tick. Rest row with presses -> no pulses.
- **Combo bonus and held key.** 9 consecutive hits -> `score`=95 (8×10 + 15), `combo`=9, `max_combo`=9. A key held across `beat_tick` does not hit the next row.
- **Same-cycle press and tick.** Correct press and `beat_tick` in the same cycle -> single `hit`, no miss, `row_counter` advances.
- **End of song and reset.** Run `NUM_ROWS` ticks -> DONE, `game_over`=1, `row_counter`=99, further ticks ignored. `start` -> all cleared, `playing`=1. `Reset` mid-PLAY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/note_judge_ctrl.sv
// note_judge_ctrl: one-lane rhythm-game sequencer and judge.
// Walks the note pattern on beat ticks, turns A/S/D keycodes into a lane
// mask, detects fresh presses and judges every non-rest row exactly once.
// Score, combo and song-status outputs are all registered.
module note_judge_ctrl #(
  parameter int NUM_ROWS     = 100,
  parameter int HIT_POINTS   = 10,
  parameter int COMBO_BONUS  = 5,
  parameter int COMBO_THRESH = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        beat_tick,
  input  logic [15:0] keycode,
  input  logic [2:0]  row_note,
  output logic [6:0]  row_counter,
  output logic        hit,
  output logic        miss,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic        playing,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0]  ROW_LAST   = 7'(NUM_ROWS - 1);
  localparam logic [15:0] PTS_BASE   = 16'(HIT_POINTS);
  localparam logic [15:0] PTS_BONUS  = 16'(HIT_POINTS + COMBO_BONUS);
  localparam logic [7:0]  BONUS_LVL  = 8'(COMBO_THRESH);

  // One keycode byte to a one-hot lane: A=left, S=middle, D=right.
  function automatic logic [2:0] decode_byte(input logic [7:0] code);
    case (code)
      8'h04:   decode_byte = 3'b100;
      8'h16:   decode_byte = 3'b010;
      8'h07:   decode_byte = 3'b001;
      default: decode_byte = 3'b000;
    endcase
  endfunction

  state_t      state, state_next;
  logic [2:0]  key_mask, prev_mask, new_press;
  logic        judged, judged_next;
  logic [6:0]  row_next;
  logic        hit_next, miss_next;
  logic [15:0] score_next;
  logic [7:0]  combo_next, max_next;

  // Judgment helpers
  logic        press_judge;
  logic        do_hit, do_miss;
  logic [15:0] hit_pts;
  logic [16:0] score_sum;
  logic [7:0]  combo_inc;

  assign key_mask  = decode_byte(keycode[15:8]) | decode_byte(keycode[7:0]);
  assign new_press = key_mask & ~prev_mask;

  // Press-judgment arithmetic, shared by every path that scores a hit.
  assign hit_pts   = (combo >= BONUS_LVL) ? PTS_BONUS : PTS_BASE;
  assign score_sum = {1'b0, score} + {1'b0, hit_pts};
  assign combo_inc = (combo == 8'hFF) ? combo : combo + 8'd1;

  // State register; synchronous reset has priority over all inputs.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and next-value logic for the whole datapath.
  always_comb begin
    // NOTE: every signal gets its hold/default value first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_next  = state;
    row_next    = row_counter;
    judged_next = judged;
    hit_next    = 1'b0;
    miss_next   = 1'b0;
    score_next  = score;
    combo_next  = combo;
    max_next    = max_combo;
    press_judge = 1'b0;
    do_hit      = 1'b0;
    do_miss     = 1'b0;

    case (state)
      IDLE, DONE: begin
        // start beats a coincident tick; outputs hold otherwise.
        if (start) begin
          state_next  = PLAY;
          row_next    = '0;
          judged_next = 1'b0;
          score_next  = '0;
          combo_next  = '0;
          max_next    = '0;
        end
      end

      PLAY: begin
        // A fresh press on an unjudged note row is judged against this row,
        // even when the row closes in the same cycle.
        press_judge = !judged && (new_press != 3'b000) && (row_note != 3'b000);
        if (press_judge) begin
          judged_next = 1'b1;
          if (new_press == row_note) do_hit  = 1'b1;
          else                       do_miss = 1'b1;
        end

        if (beat_tick) begin
          // Close-miss only if nothing judged this row, this cycle included.
          if (!judged && (row_note != 3'b000) && !press_judge) do_miss = 1'b1;
          judged_next = 1'b0;
          if (row_counter == ROW_LAST) state_next = DONE;
          else                         row_next   = row_counter + 7'd1;
        end

        if (do_hit) begin
          hit_next   = 1'b1;
          score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          combo_next = combo_inc;
          max_next   = (combo_inc > max_combo) ? combo_inc : max_combo;
        end else if (do_miss) begin
          miss_next  = 1'b1;
          combo_next = '0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_mask   <= '0;
      judged      <= 1'b0;
      row_counter <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      playing     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      prev_mask   <= key_mask;
      judged      <= judged_next;
      row_counter <= row_next;
      hit         <= hit_next;
      miss        <= miss_next;
      score       <= score_next;
      combo       <= combo_next;
      max_combo   <= max_next;
      playing     <= (state_next == PLAY);
      game_over   <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_note_judge_ctrl.sv
// Directed bench for note_judge_ctrl: hand-computed expectations per step.
module tb_note_judge_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, start, beat_tick;
  logic [15:0] keycode;
  logic [2:0]  row_note;
  logic [6:0]  row_counter;
  logic        hit, miss, playing, game_over;
  logic [15:0] score;
  logic [7:0]  combo, max_combo;

  logic [2:0]  pat [0:127];
  int          n_checks = 0;
  int          n_errors = 0;
  int          miss_seen;

  note_judge_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .beat_tick  (beat_tick),
    .keycode    (keycode),
    .row_note   (row_note),
    .row_counter(row_counter),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 Clk = ~Clk;

  // External note-pattern array, indexed by the DUT's row counter.
  assign row_note = pat[row_counter];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row"},   32'(row_counter), 0);
    check({tag, "_hit"},   32'(hit), 0);
    check({tag, "_miss"},  32'(miss), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_combo"}, 32'(combo), 0);
    check({tag, "_max"},   32'(max_combo), 0);
    check({tag, "_play"},  32'(playing), 0);
    check({tag, "_over"},  32'(game_over), 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) pat[i] = 3'b000;
    pat[0]  = 3'b100;
    pat[1]  = 3'b010;
    pat[2]  = 3'b100;
    pat[3]  = 3'b000;
    for (int i = 4; i <= 12; i++) pat[i] = 3'b001;
    pat[13] = 3'b100;
    pat[14] = 3'b100;
    pat[15] = 3'b010;
    pat[16] = 3'b001;
    pat[17] = 3'b100;
    pat[99] = 3'b100;

    Reset = 1'b1; start = 1'b0; beat_tick = 1'b0; keycode = 16'h0000;
    step(); step();
    check_all_zero("reset");

    Reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("start_play", 32'(playing), 1);
    check("start_row", 32'(row_counter), 0);

    // Row 0 (left): key held three cycles -> single hit.
    keycode = 16'h0004;
    step();
    check("r0_hit", 32'(hit), 1);
    check("r0_score", 32'(score), 10);
    check("r0_combo", 32'(combo), 1);
    step();
    check("r0_held_hit", 32'(hit), 0);
    step();
    keycode = 16'h0000; beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("r0_tick_miss", 32'(miss), 0);
    check("r0_tick_row", 32'(row_counter), 1);

    // Row 1 (middle): wrong key, then correct key in the same row.
    keycode = 16'h0007;
    step();
    check("r1_miss", 32'(miss), 1);
    check("r1_nohit", 32'(hit), 0);
    check("r1_combo", 32'(combo), 0);
    check("r1_score", 32'(score), 10);
    keycode = 16'h1600;
    step();
    check("r1_late_hit", 32'(hit), 0);
    check("r1_late_miss", 32'(miss), 0);
    keycode = 16'h0000; beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("r1_tick_miss", 32'(miss), 0);

    // Row 2 (left): no press -> close-miss the cycle after the tick.
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("r2_close_miss", 32'(miss), 1);
    check("r2_row", 32'(row_counter), 3);
    step();
    check("r2_miss_pulse", 32'(miss), 0);

    // Row 3 (rest): presses are ignored, close adds nothing.
    miss_seen = 0;
    keycode = 16'h0004; step(); miss_seen += int'(hit) + int'(miss);
    keycode = 16'h0000; step(); miss_seen += int'(hit) + int'(miss);
    keycode = 16'h0016; step(); miss_seen += int'(hit) + int'(miss);
    keycode = 16'h0000; beat_tick = 1'b1;
    step(); miss_seen += int'(hit) + int'(miss);
    beat_tick = 1'b0;
    check("rest_pulses", 32'(miss_seen), 0);
    check("rest_row", 32'(row_counter), 4);

    // Rows 4..12 (right): nine consecutive hits, bonus on the ninth.
    for (int r = 4; r <= 12; r++) begin
      keycode = 16'h0007;
      step();
      check($sformatf("combo_hit_%0d", r), 32'(hit), 1);
      keycode = 16'h0000; beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
    end
    check("combo_score", 32'(score), 105);
    check("combo_combo", 32'(combo), 9);
    check("combo_max", 32'(max_combo), 9);
    check("combo_row", 32'(row_counter), 13);

    // Rows 13/14 (left): key held across the tick does not hit row 14.
    keycode = 16'h0004;
    step();
    check("r13_hit", 32'(hit), 1);
    check("r13_score", 32'(score), 120);
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("r13_tick_row", 32'(row_counter), 14);
    check("r13_tick_miss", 32'(miss), 0);
    step();
    check("r14_held_hit", 32'(hit), 0);
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("r14_close_miss", 32'(miss), 1);
    check("r14_combo", 32'(combo), 0);
    check("r14_max", 32'(max_combo), 10);
    keycode = 16'h0000;
    step();

    // Row 15 (middle): correct press with tick -> single hit, row advances.
    keycode = 16'h0016; beat_tick = 1'b1;
    step();
    keycode = 16'h0000; beat_tick = 1'b0;
    check("r15_hit", 32'(hit), 1);
    check("r15_miss", 32'(miss), 0);
    check("r15_row", 32'(row_counter), 16);
    step();
    check("r15_after", 32'(hit) + 32'(miss), 0);

    // Row 16 (right): wrong press with tick -> exactly one miss.
    keycode = 16'h0004; beat_tick = 1'b1;
    step();
    keycode = 16'h0000; beat_tick = 1'b0;
    check("r16_miss", 32'(miss), 1);
    step();
    check("r16_single", 32'(miss), 0);

    // Row 17 (left): chord counts as a miss.
    keycode = 16'h1604;
    step();
    check("r17_chord_miss", 32'(miss), 1);
    check("r17_chord_hit", 32'(hit), 0);
    check("r17_score", 32'(score), 130);
    keycode = 16'h0000; beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("r17_row", 32'(row_counter), 18);

    // Rest rows up to the last row.
    miss_seen = 0;
    for (int i = 0; i < 200 && row_counter != 7'd99; i++) begin
      beat_tick = 1'b1; step(); miss_seen += int'(miss);
      beat_tick = 1'b0; step(); miss_seen += int'(miss);
    end
    check("run_misses", 32'(miss_seen), 0);
    check("run_row", 32'(row_counter), 99);
    check("run_playing", 32'(playing), 1);

    // Last row (left), unpressed: close-miss and move to DONE.
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("end_miss", 32'(miss), 1);
    check("end_over", 32'(game_over), 1);
    check("end_playing", 32'(playing), 0);
    check("end_row", 32'(row_counter), 99);
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    check("done_tick_row", 32'(row_counter), 99);
    check("done_tick_miss", 32'(miss), 0);
    check("done_tick_over", 32'(game_over), 1);
    keycode = 16'h0004;
    step();
    check("done_press_hit", 32'(hit), 0);
    check("done_score", 32'(score), 130);

    // start with a tick in DONE, key still held: restart, no press.
    start = 1'b1; beat_tick = 1'b1;
    step();
    start = 1'b0; beat_tick = 1'b0;
    check("restart_play", 32'(playing), 1);
    check("restart_over", 32'(game_over), 0);
    check("restart_row", 32'(row_counter), 0);
    check("restart_score", 32'(score), 0);
    check("restart_combo", 32'(combo), 0);
    check("restart_max", 32'(max_combo), 0);
    step();
    check("restart_held_hit", 32'(hit), 0);
    keycode = 16'h0000;
    step();
    keycode = 16'h0004;
    step();
    check("restart_hit", 32'(hit), 1);
    check("restart_hit_score", 32'(score), 10);
    check("restart_hit_max", 32'(max_combo), 1);

    // Reset mid-PLAY.
    Reset = 1'b1;
    step();
    check_all_zero("midreset");
    Reset = 1'b0; keycode = 16'h0000;
    step();
    check("idle_stays", 32'(playing), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
